sigdel_decim: RTL and testbench
===============================

SIGDEL_DECIM -- requirements
Module: sigdel_decim

Interface
REQ-001 The block SHALL have parameter BITLEN, default 16, meaning output sample width; it SHALL be even and at least 8.
REQ-002 The block SHALL derive localparams LOG2R = BITLEN/2, R = 2**LOG2R (decimation ratio) and ACCW = BITLEN+1 (internal word width).
REQ-003 The port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state SHALL update on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, and act as the asynchronous, active-low reset.
REQ-005 The port in_en SHALL be an input, 1 bit wide, and qualify bit_in as one bitstream sample in the current cycle.
REQ-006 The port bit_in SHALL be an input, 1 bit wide, and carry the sigma-delta bitstream, where 1 counts as 1 and 0 counts as 0.
REQ-007 The port out_data SHALL be an output, BITLEN bits wide, and carry an unsigned, offset-binary decimated sample with midscale 2**(BITLEN-1), in the same format as the DAC input word.
REQ-008 The port out_valid SHALL be an output, 1 bit wide, and indicate that out_data holds a sample.
REQ-009 The port out_ready SHALL be an input, 1 bit wide, and indicate that the consumer accepts out_data.
REQ-010 The port ovf SHALL be an output, 1 bit wide, and act as a sticky flag for a lost sample.
REQ-011 The port clr_ovf SHALL be an input, 1 bit wide, and clear ovf synchronously.

Function
REQ-012 The block SHALL implement a second-order CIC (sinc2) decimator as follows: on each cycle with in_en=1, i1 <= i1 + bit_in and i2 <= i2 + (i1 + bit_in), both ACCW bits wide with modulo-2**ACCW wrap, and with no saturation in the integrators.
REQ-013 The block SHALL hold i1, i2 and the phase counter when in_en=0.
REQ-014 The block SHALL count in_en cycles in phase counter cnt, 0..R-1, wrapping to 0; the in_en cycle with cnt==R-1 SHALL be the decimation point, and the updated i2 value SHALL be captured on that edge.
REQ-015 The block SHALL compute the comb stage modulo 2**ACCW as c1 = x - x_d, then y = c1 - c1_d, where x is the captured i2 and x_d and c1_d are the values from the previous decimation point.
REQ-016 The block SHALL saturate y as out_data = min(y, 2**BITLEN-1), so that a constant all-ones input yields 2**BITLEN-1.
REQ-017 The latency SHALL be fixed: the comb result is registered one clock after the capture, so out_valid rises 2 clocks after the decimation-point cycle.
REQ-018 The settling FSM SHALL have states FILL0 -> FILL1 -> RUN, advancing one state per decimation point; results produced in FILL0 and FILL1 SHALL be discarded with no out_valid, and only RUN SHALL emit samples.
REQ-019 The handshake SHALL transfer a sample when out_valid && out_ready; out_valid SHALL then clear unless a new sample loads on the same edge.
REQ-020 out_data SHALL stay stable while out_valid=1 && out_ready=0, except on overflow.
REQ-021 On overflow, a new sample arriving while out_valid=1 && out_ready=0 SHALL overwrite out_data, keep out_valid=1 and set ovf.
REQ-022 A new sample and a transfer on the same edge SHALL load the new sample with out_valid=1 and SHALL NOT set ovf.
REQ-023 If set and clear of ovf coincide, set SHALL win.
REQ-024 Integrators SHALL run independently of out_ready; there SHALL be no backpressure onto the bitstream.

Reset
REQ-025 On rst=0, the block SHALL asynchronously clear i1, i2, cnt, x_d, c1_d and out_data to 0, clear out_valid and ovf to 0, and set the FSM to FILL0.
REQ-026 A reset mid-window SHALL discard partial sums; the first valid sample SHALL then follow three full windows.
REQ-027 Reset release SHALL be synchronous to clk, and the first in_en SHALL be honoured on the first edge after release.

Structure
REQ-028 Shared package sigdel_pkg SHALL hold the decim_state_t enum (FILL0, FILL1, RUN) and the localparam derivation helpers used by both DAC and decimator testbenches.
REQ-029 The comb/saturate pipeline SHALL be implemented as sub-module sigdel_cic_comb (ports clk, rst, load, x, y_sat, y_stb); integrators, counter, FSM and handshake SHALL remain in the top module.

Verification
REQ-030 (BITLEN=16, R=256) With in_en=1 continuously, bit_in=1 and out_ready=1, the bench SHALL check that the first out_valid appears 3*256+2 cycles after reset release and that out_data=65535 thereafter.
REQ-031 With a constant bit_in=0, the bench SHALL check that every RUN sample is 0.
REQ-032 With alternating bit_in 1,0,1,0, the bench SHALL check that every RUN sample is 32768; with 1-in-4 ones, every RUN sample SHALL be 16384.
REQ-033 The bench SHALL drive the 16-bit DAC output stream for in_DAC=0xC000 into bit_in and check that the decoded samples settle within +/-1 LSB of 49152.
REQ-034 The bench SHALL hold out_ready=0 across two decimation points and check that ovf=1 and out_data equals the second sample; it SHALL then pulse clr_ovf and check ovf=0.
REQ-035 The bench SHALL assert rst mid-window and check that all outputs are 0 immediately without a clock, and that the next out_valid comes exactly 3*256+2 enabled cycles after release.

Source files
------------

// File: rtl/sigdel_pkg.sv
// Shared types and parameter helpers for the sigma-delta DAC/decimator family.
// Both RTL and testbenches derive ratio and word widths from BITLEN through these.
package sigdel_pkg;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } decim_state_t;

  function automatic int log2r_of(input int bitlen);
    return bitlen / 2;
  endfunction

  function automatic int ratio_of(input int bitlen);
    return 1 << (bitlen / 2);
  endfunction

  function automatic int accw_of(input int bitlen);
    return bitlen + 1;
  endfunction

endpackage

// File: rtl/sigdel_cic_comb.sv
// Two-stage CIC comb with unsigned saturation to BITLEN bits.
// One load per decimation point; result and strobe are registered one clock later.
module sigdel_cic_comb
  import sigdel_pkg::*;
#(
  parameter int BITLEN = 16,
  localparam int ACCW  = accw_of(BITLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ACCW-1:0]   x,
  output logic [BITLEN-1:0] y_sat,
  output logic              y_stb
);

  logic [ACCW-1:0] x_d;
  logic [ACCW-1:0] c1_d;
  logic [ACCW-1:0] c1;
  logic [ACCW-1:0] y;

  // The comb output is never negative in steady state, so only the top bit needs clamping.
  function automatic logic [BITLEN-1:0] sat_u(input logic [ACCW-1:0] v);
    if (v[ACCW-1]) return '1;
    return v[BITLEN-1:0];
  endfunction

  assign c1 = x - x_d;
  assign y  = c1 - c1_d;

  // p1: comb result registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_d   <= '0;
      c1_d  <= '0;
      y_sat <= '0;
      y_stb <= 1'b0;
    end else begin
      y_stb <= load;
      if (load) begin
        x_d   <= x;
        c1_d  <= c1;
        y_sat <= sat_u(y);
      end
    end
  end

endmodule

// File: rtl/sigdel_decim.sv
// Second-order CIC decimator for a 1-bit sigma-delta stream, R = 2**(BITLEN/2).
// Integrators free-run on in_en; samples leave through a valid/ready register with sticky overflow.
module sigdel_decim
  import sigdel_pkg::*;
#(
  parameter int BITLEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic              bit_in,
  output logic [BITLEN-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int LOG2R = log2r_of(BITLEN);
  localparam int R     = ratio_of(BITLEN);
  localparam int ACCW  = accw_of(BITLEN);
  localparam logic [LOG2R-1:0] CNT_LAST = LOG2R'(R - 1);

  logic [ACCW-1:0]   i1;
  logic [ACCW-1:0]   i2;
  logic [ACCW-1:0]   i1_nxt;
  logic [ACCW-1:0]   i2_nxt;
  logic [LOG2R-1:0]  cnt;
  logic              dec_pt;
  logic [ACCW-1:0]   x_p0;
  logic              load_p0;
  logic              emit_p0;
  logic              emit_p1;
  logic [BITLEN-1:0] y_sat_p1;
  logic              vld_p1;
  logic              new_smp;
  logic              xfer;
  decim_state_t      state;
  decim_state_t      state_nxt;

  assign i1_nxt = i1 + ACCW'(bit_in);
  assign i2_nxt = i2 + i1_nxt;
  assign dec_pt = in_en && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1  <= '0;
      i2  <= '0;
      cnt <= '0;
    end else if (in_en) begin
      i1  <= i1_nxt;
      i2  <= i2_nxt;
      cnt <= cnt + LOG2R'(1);
    end
  end

  // p0: capture of the updated i2 at the decimation point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_p0    <= '0;
      load_p0 <= 1'b0;
      emit_p0 <= 1'b0;
      emit_p1 <= 1'b0;
    end else begin
      load_p0 <= dec_pt;
      if (dec_pt) begin
        x_p0    <= i2_nxt;
        emit_p0 <= (state == RUN);
      end
      if (load_p0) emit_p1 <= emit_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL0;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (dec_pt) begin
      case (state)
        FILL0:   state_nxt = FILL1;
        FILL1:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  sigdel_cic_comb #(
    .BITLEN (BITLEN)
  ) u_comb (
    .clk   (clk),
    .rst   (rst),
    .load  (load_p0),
    .x     (x_p0),
    .y_sat (y_sat_p1),
    .y_stb (vld_p1)
  );

  assign new_smp = vld_p1 && emit_p1;
  assign xfer    = out_valid && out_ready;

  // p2: output register; a stalled sample is overwritten rather than stalling the stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (new_smp) begin
        out_data  <= y_sat_p1;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (new_smp && out_valid && !out_ready) ovf <= 1'b1;
      else if (clr_ovf)                        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigdel_decim.sv
// Directed bench for sigdel_decim at BITLEN=16 (R=256): latency, steady-state values,
// overflow handling and mid-window reset.
module tb_sigdel_decim;

  logic        clk;
  logic        rst;
  logic        in_en;
  logic        bit_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        clr_ovf;

  int          n_checks;
  int          n_errors;
  int          samples[$];
  logic [15:0] dac_acc;
  int          fv;

  sigdel_decim #(
    .BITLEN (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .bit_in    (bit_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) samples.push_back(int'(out_data));
  end

  task automatic check(input string tag, input int obs, input int exp_v, input int tol = 0);
    int d;
    n_checks++;
    d = obs - exp_v;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp_v, tol);
    end
  endtask

  task automatic check_run(input string tag, input int n_exp, input int value, input int tol);
    check({tag, "_count"}, samples.size(), n_exp);
    foreach (samples[i]) check(tag, samples[i], value, tol);
  endtask

  // Leaves rst released just after a falling edge so the next rising edge takes in_en.
  task automatic do_reset();
    rst       = 1'b0;
    in_en     = 1'b0;
    bit_in    = 1'b0;
    clr_ovf   = 1'b0;
    dac_acc   = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    samples.delete();
  endtask

  // mode: 0 zeros, 1 ones, 2 alternating, 3 one-in-four, 4 first-order DAC of 0xC000
  task automatic run_stream(input int mode, input int ncyc, output int first_v);
    logic [16:0] t;
    first_v = -1;
    for (int c = 1; c <= ncyc; c++) begin
      in_en = 1'b1;
      case (mode)
        0: bit_in = 1'b0;
        1: bit_in = 1'b1;
        2: bit_in = ((c - 1) % 2) == 0;
        3: bit_in = ((c - 1) % 4) == 0;
        default: begin
          t       = {1'b0, dac_acc} + 17'h0C000;
          dac_acc = t[15:0];
          bit_in  = t[16];
        end
      endcase
      @(posedge clk);
      #1;
      if (first_v < 0 && out_valid) first_v = c;
    end
    in_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    out_ready = 1'b1;
    rst       = 1'b0;
    in_en     = 1'b0;
    bit_in    = 1'b0;
    clr_ovf   = 1'b0;
    #13;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data",  int'(out_data),  0);
    check("rst_ovf",   int'(ovf),       0);

    do_reset();
    run_stream(1, 1290, fv);
    check("ones_latency", fv, 3 * 256 + 2);
    check_run("ones", 3, 65535, 0);

    do_reset();
    run_stream(0, 1290, fv);
    check_run("zeros", 3, 0, 0);

    do_reset();
    run_stream(2, 1290, fv);
    check_run("alt", 3, 32768, 0);

    do_reset();
    run_stream(3, 1290, fv);
    check_run("quarter", 3, 16384, 0);

    do_reset();
    run_stream(4, 1540, fv);
    check_run("dac_c000", 4, 49152, 1);

    // Stall across two decimation points: ones-window sample then the ones->zeros transition
    do_reset();
    out_ready = 1'b0;
    run_stream(1, 768, fv);
    run_stream(0, 260, fv);
    check("stall_first_valid", fv, 2);
    check("ovf_valid", int'(out_valid), 1);
    check("ovf_data",  int'(out_data),  32640);
    check("ovf_set",   int'(ovf),       1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    check("ovf_clr",        int'(ovf),       0);
    check("ovf_clr_valid",  int'(out_valid), 1);
    check("ovf_clr_data",   int'(out_data),  32640);

    // Mid-window asynchronous reset while a sample is held
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", int'(out_valid), 0);
    check("async_data",  int'(out_data),  0);
    check("async_ovf",   int'(ovf),       0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    samples.delete();
    run_stream(1, 780, fv);
    check("rerun_latency", fv, 3 * 256 + 2);
    check_run("rerun", 1, 65535, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
